cpu_cfg_regs: RTL and testbench

CPU-side configuration slave for the ATM switch. It terminates the `cpu_ifc` Peripheral modport and runs the Intel- and Motorola-style bus handshakes. It owns the per-VPI cell forwarding table (`CellCfgType` entries) and serves single-cycle lookups to the receive-side cell path. It sits between the CPU bus model/test program and the switch core's forwarding logic.

---
 rtl/cpu_cfg_regs_pkg.sv | 16 +
 rtl/cpu_ifc.sv | 24 ++
 rtl/cpu_cfg_regs_table.sv | 54 +++++
 rtl/cpu_cfg_regs.sv | 99 +++++++++
 tb/tb_cpu_cfg_regs.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_cfg_regs_pkg.sv
// Shared types for the CPU configuration slave: the forwarding-table entry
// format, table geometry and the bus-handshake state encoding.
package definitions;

   localparam int unsigned NumTx      = 4;
   localparam int unsigned NumEntries = 256;

   // One forwarding-table entry; FWD occupies the upper bits of the bus word.
   typedef struct packed {
      logic [NumTx-1:0] FWD;
      logic [11:0]      VPI;
   } CellCfgType;

   typedef enum logic [1:0] {IDLE, ACCESS, ACK} CpuBusState_t;

endpackage

// File: rtl/cpu_ifc.sv
// CPU bus bundle shared by the bus master (test program) and the peripheral.
interface cpu_ifc;
   import definitions::*;

   logic       BusMode;   // 1: Intel, 0: Motorola
   logic [11:0] Addr;
   logic       Sel;       // active-low chip select
   CellCfgType DataIn;
   logic       Rd_DS;     // Intel RD# / Motorola DS#
   logic       Wr_RW;     // Intel WR# / Motorola R/W# (1 = read)
   CellCfgType DataOut;
   logic       Rdy_Dtack; // active-low acknowledge

   modport Peripheral (
      input  BusMode, Addr, Sel, DataIn, Rd_DS, Wr_RW,
      output DataOut, Rdy_Dtack
   );

   modport Test (
      output BusMode, Addr, Sel, DataIn, Rd_DS, Wr_RW,
      input  DataOut, Rdy_Dtack
   );

endinterface

// File: rtl/cpu_cfg_regs_table.sv
// Forwarding table: flop array cleared by reset, one synchronous write port and
// two registered read ports. Reads sample the array before the same-edge write.
module cell_cfg_table
   import definitions::*;
#(
   parameter  int unsigned NumEntries = definitions::NumEntries,
   localparam int unsigned AddrW      = $clog2(NumEntries)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AddrW-1:0] waddr,
   input  CellCfgType       wdata,
   input  logic             cpu_rd_en,
   input  logic             cpu_rd_zero,
   input  logic [AddrW-1:0] cpu_raddr,
   output CellCfgType       cpu_rdata,
   input  logic             lk_rd_en,
   input  logic [AddrW-1:0] lk_raddr,
   output CellCfgType       lk_rdata
);

   CellCfgType mem [NumEntries];

   // Table storage: clear on reset, single write port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NumEntries); i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // CPU read register: loads only when asked, so it holds through the ack phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_rdata <= '0;
      end else if (cpu_rd_en) begin
         cpu_rdata <= cpu_rd_zero ? '0 : mem[cpu_raddr];
      end
   end

   // Lookup read register for the cell path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lk_rdata <= '0;
      end else if (lk_rd_en) begin
         lk_rdata <= mem[lk_raddr];
      end
   end

endmodule

// File: rtl/cpu_cfg_regs.sv
// CPU configuration slave: Intel/Motorola bus handshake, address decode onto
// the forwarding table, and the single-cycle lookup port for the cell path.
module cpu_cfg_regs
   import definitions::*;
(
   input  logic       clk,
   input  logic       rst,
   cpu_ifc.Peripheral cpu,
   input  logic       lk_req,
   input  logic [7:0] lk_vpi,
   output logic       lk_vld,
   output CellCfgType lk_cfg
);

   CpuBusState_t state_q, state_d;
   logic         mode_q, rd_q, rdy_q;
   logic [11:0]  addr_q;
   CellCfgType   data_q;
   CellCfgType   cpu_rdata;

   logic intel_rd, intel_wr, moto_go, start, start_rd, released, in_range;

   // Strobe decode; RD# and WR# low together matches neither Intel term.
   assign intel_rd = cpu.BusMode & ~cpu.Sel & ~cpu.Rd_DS & cpu.Wr_RW;
   assign intel_wr = cpu.BusMode & ~cpu.Sel & cpu.Rd_DS & ~cpu.Wr_RW;
   assign moto_go  = ~cpu.BusMode & ~cpu.Sel & ~cpu.Rd_DS;
   // rdy_q still low on the first IDLE cycle after a release blocks an early restart.
   assign start    = (intel_rd | intel_wr | moto_go) & rdy_q;
   assign start_rd = intel_rd | (moto_go & cpu.Wr_RW);
   assign released = mode_q ? (rd_q ? cpu.Rd_DS : cpu.Wr_RW) : (cpu.Rd_DS | cpu.Sel);
   assign in_range = (addr_q[11:8] == 4'h0);

   // Next-state logic of the bus handshake.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = ACCESS;
         ACCESS:  state_d = ACK;
         ACK:     if (released) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and acknowledge registers; ack lags the ACK state by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         rdy_q   <= (state_q != ACK);
      end
   end

   // Capture mode, direction, address and write data when a cycle starts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= 1'b0;
         rd_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else if (state_q == IDLE && start) begin
         mode_q <= cpu.BusMode;
         rd_q   <= start_rd;
         addr_q <= cpu.Addr;
         data_q <= cpu.DataIn;
      end
   end

   // Lookup valid is a one-cycle echo of the request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lk_vld <= 1'b0;
      end else begin
         lk_vld <= lk_req;
      end
   end

   cell_cfg_table #(
      .NumEntries (NumEntries)
   ) u_table (
      .clk         (clk),
      .rst         (rst),
      .we          ((state_q == ACCESS) & ~rd_q & in_range),
      .waddr       (addr_q[7:0]),
      .wdata       (data_q),
      .cpu_rd_en   ((state_q == ACCESS) & rd_q),
      .cpu_rd_zero (~in_range),
      .cpu_raddr   (addr_q[7:0]),
      .cpu_rdata   (cpu_rdata),
      .lk_rd_en    (lk_req),
      .lk_raddr    (lk_vpi),
      .lk_rdata    (lk_cfg)
   );

   assign cpu.DataOut   = cpu_rdata;
   assign cpu.Rdy_Dtack = rdy_q;

endmodule

// File: tb/tb_cpu_cfg_regs.sv
// Bench for cpu_cfg_regs: bus cycles in both modes, decode range, lookup
// collision, mid-cycle reset and streaming lookups, checked against a queue.
module tb_cpu_cfg_regs;
   import definitions::*;

   logic       clk;
   logic       rst;
   logic       lk_req;
   logic [7:0] lk_vpi;
   logic       lk_vld;
   CellCfgType lk_cfg;

   cpu_ifc bus ();

   cpu_cfg_regs dut (
      .clk    (clk),
      .rst    (rst),
      .cpu    (bus),
      .lk_req (lk_req),
      .lk_vpi (lk_vpi),
      .lk_vld (lk_vld),
      .lk_cfg (lk_cfg)
   );

   int total = 0;
   int bad   = 0;
   CellCfgType exp_q [$];
   CellCfgType model [256];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish, required to finish in time");
      $fatal(1, "watchdog");
   end

   // Runs one bus cycle. ack_lat counts edges from the strobe sample to ack low
   // (20 = never), rel_lat counts edges from release to ack high, hold_hi counts
   // hold cycles where ack rose or DataOut moved.
   task automatic bus_cycle(input bit intel, input bit rd, input logic [11:0] addr,
                            input CellCfgType wdata, input int hold,
                            output int ack_lat, output CellCfgType rdata,
                            output int rel_lat, output int hold_hi);
      @(negedge clk);
      bus.BusMode = intel;
      bus.Addr    = addr;
      bus.DataIn  = wdata;
      bus.Sel     = 1'b0;
      if (intel) begin
         bus.Rd_DS = ~rd;
         bus.Wr_RW = rd;
      end else begin
         bus.Rd_DS = 1'b0;
         bus.Wr_RW = rd;
      end
      ack_lat = 0;
      while (ack_lat < 20) begin
         @(negedge clk);
         ack_lat++;
         if (bus.Rdy_Dtack === 1'b0) break;
      end
      rdata   = bus.DataOut;
      hold_hi = 0;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         if (bus.Rdy_Dtack !== 1'b0 || bus.DataOut !== rdata) hold_hi++;
      end
      bus.Sel   = 1'b1;
      bus.Rd_DS = 1'b1;
      bus.Wr_RW = 1'b1;
      rel_lat   = 0;
      while (rel_lat < 20) begin
         @(negedge clk);
         rel_lat++;
         if (bus.Rdy_Dtack === 1'b1) break;
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      lk_req     = 1'b0;
      lk_vpi     = '0;
      bus.BusMode = 1'b1;
      bus.Addr   = '0;
      bus.DataIn = '0;
      bus.Sel    = 1'b1;
      bus.Rd_DS  = 1'b1;
      bus.Wr_RW  = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (bus.Rdy_Dtack !== 1'b1) begin
         bad++; $display("FAIL reset_rdy: got %b want 1", bus.Rdy_Dtack);
      end
      total++;
      if (bus.DataOut !== 16'h0) begin
         bad++; $display("FAIL reset_dataout: got %h want 0000", bus.DataOut);
      end
      total++;
      if (lk_vld !== 1'b0) begin
         bad++; $display("FAIL reset_lk_vld: got %b want 0", lk_vld);
      end
      total++;
      if (lk_cfg !== 16'h0) begin
         bad++; $display("FAIL reset_lk_cfg: got %h want 0000", lk_cfg);
      end
      rst = 1'b0;
   endtask

   task automatic test_intel();
      int ack, rel, hi, low_cnt;
      CellCfgType rd, e;
      CellCfgType w = CellCfgType'{FWD: 4'b1010, VPI: 12'h123};
      bus_cycle(1'b1, 1'b0, 12'h005, w, 0, ack, rd, rel, hi);
      total++;
      if (ack !== 3) begin
         bad++; $display("FAIL intel_wr_ack_lat: got %0d edges want 3", ack);
      end
      total++;
      if (rel !== 2) begin
         bad++; $display("FAIL intel_wr_rel_lat: got %0d edges want 2", rel);
      end
      exp_q.push_back(w);
      bus_cycle(1'b1, 1'b1, 12'h005, '0, 0, ack, rd, rel, hi);
      e = exp_q.pop_front();
      total++;
      if (ack !== 3) begin
         bad++; $display("FAIL intel_rd_ack_lat: got %0d edges want 3", ack);
      end
      total++;
      if (rd !== e) begin
         bad++; $display("FAIL intel_rd_data: got %h want %h", rd, e);
      end
      // RD# and WR# low together must be ignored.
      @(negedge clk);
      bus.Addr = 12'h005; bus.DataIn = 16'hFFFF;
      bus.Sel = 1'b0; bus.Rd_DS = 1'b0; bus.Wr_RW = 1'b0;
      low_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.Rdy_Dtack !== 1'b1) low_cnt++;
      end
      bus.Sel = 1'b1; bus.Rd_DS = 1'b1; bus.Wr_RW = 1'b1;
      total++;
      if (low_cnt !== 0) begin
         bad++; $display("FAIL intel_proto_err_ack: got %0d ack cycles want 0", low_cnt);
      end
      exp_q.push_back(w);
      bus_cycle(1'b1, 1'b1, 12'h005, '0, 0, ack, rd, rel, hi);
      e = exp_q.pop_front();
      total++;
      if (rd !== e || ack !== 3) begin
         bad++; $display("FAIL intel_proto_err_entry: got %h lat %0d want %h lat 3", rd, ack, e);
      end
   endtask

   task automatic test_motorola();
      int ack, rel, hi;
      CellCfgType rd, e;
      CellCfgType w = CellCfgType'{FWD: 4'b0001, VPI: 12'h0AB};
      bus_cycle(1'b0, 1'b0, 12'h0FF, w, 0, ack, rd, rel, hi);
      total++;
      if (ack !== 3) begin
         bad++; $display("FAIL moto_wr_ack_lat: got %0d edges want 3", ack);
      end
      exp_q.push_back(w);
      bus_cycle(1'b0, 1'b1, 12'h0FF, '0, 10, ack, rd, rel, hi);
      e = exp_q.pop_front();
      total++;
      if (ack !== 3) begin
         bad++; $display("FAIL moto_rd_ack_lat: got %0d edges want 3", ack);
      end
      total++;
      if (rd !== e) begin
         bad++; $display("FAIL moto_rd_data: got %h want %h", rd, e);
      end
      total++;
      if (hi !== 0) begin
         bad++; $display("FAIL moto_hold_ack: got %0d unstable cycles want 0", hi);
      end
      total++;
      if (rel !== 2) begin
         bad++; $display("FAIL moto_rel_lat: got %0d edges want 2", rel);
      end
   endtask

   task automatic test_out_of_range();
      int ack, rel, hi;
      CellCfgType rd, e;
      bus_cycle(1'b1, 1'b0, 12'h1FF, 16'hFFFF, 0, ack, rd, rel, hi);
      total++;
      if (ack !== 3) begin
         bad++; $display("FAIL oor_wr_ack_lat: got %0d edges want 3", ack);
      end
      exp_q.push_back(CellCfgType'{FWD: 4'b0001, VPI: 12'h0AB});
      bus_cycle(1'b1, 1'b1, 12'h0FF, '0, 0, ack, rd, rel, hi);
      e = exp_q.pop_front();
      total++;
      if (rd !== e) begin
         bad++; $display("FAIL oor_entry_ff_kept: got %h want %h", rd, e);
      end
      exp_q.push_back('0);
      bus_cycle(1'b0, 1'b1, 12'h1FF, '0, 0, ack, rd, rel, hi);
      e = exp_q.pop_front();
      total++;
      if (ack !== 3) begin
         bad++; $display("FAIL oor_rd_ack_lat: got %0d edges want 3", ack);
      end
      total++;
      if (rd !== e) begin
         bad++; $display("FAIL oor_rd_data: got %h want %h", rd, e);
      end
   endtask

   task automatic test_collision();
      int n;
      CellCfgType e;
      CellCfgType w = CellCfgType'{FWD: 4'b0110, VPI: 12'h777};
      @(negedge clk);
      bus.BusMode = 1'b1; bus.Addr = 12'h007; bus.DataIn = w;
      bus.Sel = 1'b0; bus.Rd_DS = 1'b1; bus.Wr_RW = 1'b0;
      @(negedge clk);
      // FSM is in ACCESS now: the lookup shares the write edge.
      lk_req = 1'b1; lk_vpi = 8'd7;
      exp_q.push_back('0);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (lk_vld !== 1'b1 || lk_cfg !== e) begin
         bad++; $display("FAIL collision_old: got vld %b cfg %h want vld 1 cfg %h", lk_vld, lk_cfg, e);
      end
      exp_q.push_back(w);
      @(negedge clk);
      lk_req = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (lk_vld !== 1'b1 || lk_cfg !== e) begin
         bad++; $display("FAIL collision_new: got vld %b cfg %h want vld 1 cfg %h", lk_vld, lk_cfg, e);
      end
      @(negedge clk);
      total++;
      if (lk_vld !== 1'b0) begin
         bad++; $display("FAIL lk_vld_pulse: got %b want 0", lk_vld);
      end
      n = 0;
      while (bus.Rdy_Dtack !== 1'b0 && n < 20) begin
         @(negedge clk); n++;
      end
      bus.Sel = 1'b1; bus.Rd_DS = 1'b1; bus.Wr_RW = 1'b1;
      n = 0;
      while (bus.Rdy_Dtack !== 1'b1 && n < 20) begin
         @(negedge clk); n++;
      end
      total++;
      if (bus.Rdy_Dtack !== 1'b1) begin
         bad++; $display("FAIL collision_cycle_end: got rdy %b want 1", bus.Rdy_Dtack);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      CellCfgType e;
      @(negedge clk);
      bus.BusMode = 1'b1; bus.Addr = 12'h005;
      bus.Sel = 1'b0; bus.Rd_DS = 1'b0; bus.Wr_RW = 1'b1;
      n = 0;
      while (bus.Rdy_Dtack !== 1'b0 && n < 20) begin
         @(negedge clk); n++;
      end
      total++;
      if (bus.Rdy_Dtack !== 1'b0 || bus.DataOut !== 16'hA123) begin
         bad++;
         $display("FAIL rstmid_in_ack: got rdy %b data %h want rdy 0 data a123",
                  bus.Rdy_Dtack, bus.DataOut);
      end
      rst = 1'b1;
      #1;
      total++;
      if (bus.Rdy_Dtack !== 1'b1) begin
         bad++; $display("FAIL rstmid_rdy: got %b want 1", bus.Rdy_Dtack);
      end
      total++;
      if (bus.DataOut !== 16'h0) begin
         bad++; $display("FAIL rstmid_dataout: got %h want 0000", bus.DataOut);
      end
      @(negedge clk);
      bus.Sel = 1'b1; bus.Rd_DS = 1'b1; bus.Wr_RW = 1'b1;
      rst = 1'b0;
      for (int i = 0; i <= 256; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = exp_q.pop_front();
            total++;
            if (lk_vld !== 1'b1 || lk_cfg !== e) begin
               bad++;
               $display("FAIL rstmid_lookup[%0d]: got vld %b cfg %h want vld 1 cfg %h",
                        i - 1, lk_vld, lk_cfg, e);
            end
         end
         if (i < 256) begin
            lk_req = 1'b1; lk_vpi = i[7:0];
            exp_q.push_back('0);
         end else begin
            lk_req = 1'b0;
         end
      end
   endtask

   task automatic test_stream();
      int ack, rel, hi;
      CellCfgType rd, e;
      for (int i = 0; i < 256; i++) begin
         model[i] = CellCfgType'{FWD: i[3:0], VPI: 12'(i * 7 + 1)};
         bus_cycle(i[0], 1'b0, {4'h0, i[7:0]}, model[i], 0, ack, rd, rel, hi);
         total++;
         if (ack !== 3) begin
            bad++; $display("FAIL prog_ack_lat[%0d]: got %0d edges want 3", i, ack);
         end
      end
      for (int i = 0; i <= 256; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = exp_q.pop_front();
            total++;
            if (lk_vld !== 1'b1 || lk_cfg !== e) begin
               bad++;
               $display("FAIL stream_lookup[%0d]: got vld %b cfg %h want vld 1 cfg %h",
                        i - 1, lk_vld, lk_cfg, e);
            end
         end
         if (i < 256) begin
            lk_req = 1'b1; lk_vpi = i[7:0];
            exp_q.push_back(model[i]);
         end else begin
            lk_req = 1'b0;
         end
      end
      @(negedge clk);
      total++;
      if (lk_vld !== 1'b0) begin
         bad++; $display("FAIL stream_end_vld: got %b want 0", lk_vld);
      end
   endtask

   initial begin
      test_reset();
      test_intel();
      test_motorola();
      test_out_of_range();
      test_collision();
      test_reset_mid();
      test_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
